// File: rtl/imem_boot_arbiter.sv
// Instruction-memory boot arbiter.
// Sequences a single-port instruction RAM through three phases. In LOAD the
// boot loader streams words into the RAM. In HOLD the port is quiet while the
// CPU is still held in reset. In RUN the CPU owns the port for fetches.
// A reload request in RUN drops the CPU back into reset and reopens LOAD.
// RAM contents are never cleared here; only the control state is reset.
module imem_boot_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  input  logic              reload,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic [31:0]       if_rdata,
  output logic              if_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              cpu_rst_n,
  output logic              boot_done,
  output logic              ld_err,
  output logic [ADDR_W:0]   load_count
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // HOLD counter runs 0 .. HOLD_CYCLES-1; keep at least one bit so the
  // declaration stays legal when HOLD_CYCLES is 1.
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

  // load_count saturates at the number of RAM words.
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic              ld_err_q, ld_err_d;
  logic              cpu_rst_n_q;
  logic              boot_done_q;
  logic              if_rvalid_q;
  logic              ld_hs;
  logic              ld_good;
  logic              fetch_gnt;

  // Fetch address bits that never reach the RAM: byte offset and the bits
  // above the RAM window are ignored by design.
  logic              unused_if_bits;
  assign unused_if_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0]};

  // A loader word is acceptable only when word-aligned and inside the RAM.
  assign ld_good = (ld_addr[1:0] == 2'b00) &&
                   ((ld_addr >> (ADDR_W + 2)) == 32'd0);

  assign ld_hs     = (state_q == ST_LOAD) && ld_valid;
  // Reload has priority over a same-cycle fetch so no read is ever issued in
  // the cycle that leaves RUN.
  assign fetch_gnt = (state_q == ST_RUN) && if_req && !reload;

  // Next-state logic and combinational RAM-port steering.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    load_count_d = load_count_q;
    ld_err_d     = ld_err_q;
    ld_ready     = 1'b0;
    if_gnt       = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = 32'd0;

    unique case (state_q)
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_hs) begin
          if (ld_good) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = ld_addr[ADDR_W+1:2];
            ram_wdata = ld_data;
            if (load_count_q != CNT_MAX) begin
              load_count_d = load_count_q + 1'b1;
            end
          end else begin
            ld_err_d = 1'b1;
          end
          if (ld_last) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end
        end
      end

      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (reload) begin
          state_d      = ST_LOAD;
          load_count_d = '0;
        end else if (fetch_gnt) begin
          if_gnt   = 1'b1;
          ram_en   = 1'b1;
          ram_addr = if_addr[ADDR_W+1:2];
        end
      end

      default: begin
        state_d    = ST_LOAD;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Control state register; async reset abandons any phase and reopens LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      hold_cnt_q   <= '0;
      load_count_q <= '0;
      ld_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      load_count_q <= load_count_d;
      ld_err_q     <= ld_err_d;
    end
  end

  // CPU reset and boot flag track the RUN state, registered on the same edge
  // that enters or leaves RUN so they are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rst_n_q <= 1'b0;
      boot_done_q <= 1'b0;
    end else begin
      cpu_rst_n_q <= (state_d == ST_RUN);
      boot_done_q <= (state_d == ST_RUN);
    end
  end

  // Read-data valid follows each grant by the RAM's one-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_q <= 1'b0;
    end else begin
      if_rvalid_q <= fetch_gnt;
    end
  end

  assign if_rvalid  = if_rvalid_q;
  // Data is masked to zero outside valid cycles so stale RAM output never leaks.
  assign if_rdata   = if_rvalid_q ? ram_rdata : 32'd0;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign boot_done  = boot_done_q;
  assign ld_err     = ld_err_q;
  assign load_count = load_count_q;

endmodule
